uart_tx_arbiter: RTL and testbench

Round-robin arbiter and launch sequencer that shares the transmitter of one `UART_TX_RX_MODULE` between `NUM_REQUESTERS` independent byte sources. It sits between the requesters and the UART's `IN_TX_LAUNCH`/`IN_TX_DATA` inputs, and observes `OUT_TX_ACTIVE`/`OUT_TX_DONE`. Each accepted byte is latched and launched exactly once. The requester is then told whether the frame completed or timed out.

---
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART-side signals of the
// transmitter arbiter, grouped with master/slave views.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQUESTERS           = 4,
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8
);
    localparam int N   = NUM_REQUESTERS;
    localparam int W   = NUM_OF_DATA_BITS_IN_PACK;
    localparam int IDW = $clog2(N);

    logic [N-1:0]   IN_REQ_VALID;
    logic [N*W-1:0] IN_REQ_DATA;
    logic [N-1:0]   OUT_REQ_ACCEPT;
    logic [N-1:0]   OUT_REQ_DONE;
    logic [N-1:0]   OUT_REQ_ERROR;
    logic           OUT_TX_LAUNCH;
    logic [W-1:0]   OUT_TX_DATA;
    logic           IN_TX_ACTIVE;
    logic           IN_TX_DONE;
    logic           OUT_BUSY;
    logic [IDW-1:0] OUT_GRANT_ID;

    modport master (
        output IN_REQ_VALID, IN_REQ_DATA, IN_TX_ACTIVE, IN_TX_DONE,
        input  OUT_REQ_ACCEPT, OUT_REQ_DONE, OUT_REQ_ERROR,
        input  OUT_TX_LAUNCH, OUT_TX_DATA, OUT_BUSY, OUT_GRANT_ID
    );

    modport slave (
        input  IN_REQ_VALID, IN_REQ_DATA, IN_TX_ACTIVE, IN_TX_DONE,
        output OUT_REQ_ACCEPT, OUT_REQ_DONE, OUT_REQ_ERROR,
        output OUT_TX_LAUNCH, OUT_TX_DATA, OUT_BUSY, OUT_GRANT_ID
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// byte sources, with launch handshake, completion and timeout reporting.
module uart_tx_arbiter #(
    parameter int NUM_REQUESTERS           = 4,
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int TIMEOUT_CYCLES           = 4096,
    parameter int GAP_CYCLES               = 2
) (
    input logic              IN_CLOCK,
    input logic              IN_RESET_N,
    uart_tx_arbiter_if.slave bus
);
    localparam int N    = NUM_REQUESTERS;
    localparam int W    = NUM_OF_DATA_BITS_IN_PACK;
    localparam int IDW  = $clog2(N);
    localparam int MAXC = (TIMEOUT_CYCLES > GAP_CYCLES) ?
                          TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [N-1:0] ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_GAP
    } state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [IDW-1:0] r_last, r_grant, w_pick;
    logic [W-1:0]   r_data, w_data;
    logic [N-1:0]   r_accept, r_done, r_error;
    logic [N-1:0]   w_accept, w_done, w_error;
    logic           r_launch, r_busy, w_launch, w_busy;
    logic           w_found, w_in_frame, w_tmo;
    logic           w_fin, w_abort, w_gap_ok;
    int             w_best, w_dist;

    // Pick the nearest valid requester after the last one served
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_data  = '0;
        w_best  = N;
        w_dist  = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = i - int'(r_last) - 1;
            if (w_dist < 0) w_dist = w_dist + N;
            if (bus.IN_REQ_VALID[i] && w_dist < w_best) begin
                w_best  = w_dist;
                w_found = 1'b1;
                w_pick  = IDW'(i);
                w_data  = bus.IN_REQ_DATA[i*W +: W];
            end
        end
    end

    // Frame terminating events; a real exit event beats the timeout
    always_comb begin
        w_in_frame = (r_state == S_LAUNCH) || (r_state == S_WAIT);
        w_tmo      = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
        w_fin      = w_in_frame && bus.IN_TX_DONE;
        w_abort    = w_in_frame && !bus.IN_TX_DONE && w_tmo &&
                     !((r_state == S_LAUNCH) && bus.IN_TX_ACTIVE);
        w_gap_ok   = (r_cnt >= CW'(GAP_CYCLES - 1)) && !bus.IN_TX_ACTIVE;
    end

    // State register
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_found) w_next = S_LAUNCH;
            S_LAUNCH: begin
                if (w_fin || w_abort)      w_next = S_GAP;
                else if (bus.IN_TX_ACTIVE) w_next = S_WAIT;
            end
            S_WAIT:   if (w_fin || w_abort) w_next = S_GAP;
            S_GAP:    if (w_gap_ok) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_accept = '0;
        w_done   = '0;
        w_error  = '0;
        if ((r_state == S_IDLE) && w_found) w_accept = ONE << w_pick;
        if (w_fin)   w_done  = ONE << r_grant;
        if (w_abort) w_error = ONE << r_grant;
        w_launch = (w_next == S_LAUNCH);
        w_busy   = (w_next != S_IDLE);
    end

    // Per-state cycle counter, cleared on every state change
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N)             r_cnt <= '0;
        else if (r_state != w_next)  r_cnt <= '0;
        else if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end

    // Grant bookkeeping: data and id latch on accept, last on finish
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_data  <= '0;
            r_grant <= '0;
            r_last  <= IDW'(N - 1);
        end else begin
            if ((r_state == S_IDLE) && w_found) begin
                r_data  <= w_data;
                r_grant <= w_pick;
            end
            if (w_fin || w_abort) r_last <= r_grant;
        end
    end

    // Output registers
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            r_accept <= '0;
            r_done   <= '0;
            r_error  <= '0;
            r_launch <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_accept <= w_accept;
            r_done   <= w_done;
            r_error  <= w_error;
            r_launch <= w_launch;
            r_busy   <= w_busy;
        end
    end

    assign bus.OUT_REQ_ACCEPT = r_accept;
    assign bus.OUT_REQ_DONE   = r_done;
    assign bus.OUT_REQ_ERROR  = r_error;
    assign bus.OUT_TX_LAUNCH  = r_launch;
    assign bus.OUT_TX_DATA    = r_data;
    assign bus.OUT_BUSY       = r_busy;
    assign bus.OUT_GRANT_ID   = r_grant;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table of arbitration vectors plus hand sequences,
// checked against a scoreboard of expected grants and completions.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int TMO   = 16;
    localparam int GAP   = 2;
    localparam int FRAME = 8;

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         err;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] d;
        int         exp_id;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(
        .NUM_REQUESTERS(N), .NUM_OF_DATA_BITS_IN_PACK(W)
    ) bus ();

    uart_tx_arbiter #(
        .NUM_REQUESTERS(N), .NUM_OF_DATA_BITS_IN_PACK(W),
        .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .IN_CLOCK(clk), .IN_RESET_N(rst_n), .bus(bus.slave)
    );

    int   n_vec = 0, n_bad = 0, n_acc = 0, n_fin = 0;
    int   cyc = 0, t_done = 0;
    bit   chk_gap = 1'b0;
    exp_t q_exp[$], q_done[$];
    exp_t m_e;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: mode 0 normal frame, 1 dead line, 2 DONE without ACTIVE
    int         m_mode = 0, m_phase = 0, m_cnt = 0;
    logic [7:0] m_rx = 8'h00;
    always @(negedge clk) begin
        bus.IN_TX_DONE = 1'b0;
        if (!rst_n || m_mode == 1) begin
            bus.IN_TX_ACTIVE = 1'b0;
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (bus.OUT_TX_LAUNCH) begin
                m_rx    = bus.OUT_TX_DATA;
                m_cnt   = 0;
                m_phase = 1;
                if (m_mode == 0) bus.IN_TX_ACTIVE = 1'b1;
            end
        end else if (m_phase == 1) begin
            m_cnt++;
            if (m_mode == 0 && m_cnt == FRAME) begin
                bus.IN_TX_ACTIVE = 1'b0;
                bus.IN_TX_DONE   = 1'b1;
                m_phase = 2;
            end
            if (m_mode == 2 && m_cnt == TMO - 1) begin
                bus.IN_TX_DONE = 1'b1;
                m_phase = 2;
            end
        end else if (!bus.OUT_TX_LAUNCH) begin
            m_phase = 0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (|{bus.OUT_REQ_ACCEPT, bus.OUT_REQ_DONE, bus.OUT_REQ_ERROR})
                check("pulse_onehot", $countones({bus.OUT_REQ_ACCEPT,
                      bus.OUT_REQ_DONE, bus.OUT_REQ_ERROR}), 1);
            if (|bus.OUT_REQ_ACCEPT) begin
                n_acc++;
                if (q_exp.size() == 0) begin
                    check("unexpected_accept", bus.OUT_REQ_ACCEPT, 0);
                end else begin
                    m_e = q_exp.pop_front();
                    check("accept_vec", bus.OUT_REQ_ACCEPT, 32'(1) << m_e.id);
                    check("grant_id", bus.OUT_GRANT_ID, m_e.id);
                    check("tx_data", bus.OUT_TX_DATA, m_e.data);
                    check("launch_on_accept", bus.OUT_TX_LAUNCH, 1);
                    if (chk_gap) check("gap_spacing", cyc - t_done, GAP + 1);
                    q_done.push_back(m_e);
                end
            end
            if (|bus.OUT_REQ_DONE) begin
                n_fin++;
                t_done = cyc;
                if (q_done.size() == 0) begin
                    check("unexpected_done", bus.OUT_REQ_DONE, 0);
                end else begin
                    m_e = q_done.pop_front();
                    check("done_vec", bus.OUT_REQ_DONE, 32'(1) << m_e.id);
                    check("done_not_error", m_e.err, 0);
                    check("rx_byte", m_rx, m_e.data);
                    check("data_stable", bus.OUT_TX_DATA, m_e.data);
                end
            end
            if (|bus.OUT_REQ_ERROR) begin
                n_fin++;
                if (q_done.size() == 0) begin
                    check("unexpected_error", bus.OUT_REQ_ERROR, 0);
                end else begin
                    m_e = q_done.pop_front();
                    check("error_vec", bus.OUT_REQ_ERROR, 32'(1) << m_e.id);
                    check("error_not_done", m_e.err, 1);
                    check("launch_dropped", bus.OUT_TX_LAUNCH, 0);
                    check("data_stable", bus.OUT_TX_DATA, m_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acc(output int n);
        int s;
        s = n_acc;
        n = 0;
        while (n_acc == s && n < 60) begin
            tick();
            n++;
        end
        if (n_acc == s) check("accept_wait_expired", 0, 1);
    endtask

    task automatic wait_fin(output int n);
        int s;
        s = n_fin;
        n = 0;
        while (n_fin == s && n < 60) begin
            tick();
            n++;
        end
        if (n_fin == s) check("finish_wait_expired", 0, 1);
    endtask

    task automatic drive(logic [3:0] mask, logic [7:0] d);
        bus.IN_REQ_VALID = mask;
        for (int j = 0; j < N; j++) bus.IN_REQ_DATA[j*W +: W] = d + 8'(j);
    endtask

    task automatic expect_grant(int id, logic [7:0] d, bit err);
        exp_t e;
        e.id   = id;
        e.data = d + 8'(id);
        e.err  = err;
        q_exp.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.IN_REQ_VALID = '0;
        tick();
        tick();
        q_exp.delete();
        q_done.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_zero(string tag);
        check({tag, "_accept"}, bus.OUT_REQ_ACCEPT, 0);
        check({tag, "_done"}, bus.OUT_REQ_DONE, 0);
        check({tag, "_error"}, bus.OUT_REQ_ERROR, 0);
        check({tag, "_launch"}, bus.OUT_TX_LAUNCH, 0);
        check({tag, "_data"}, bus.OUT_TX_DATA, 0);
        check({tag, "_busy"}, bus.OUT_BUSY, 0);
        check({tag, "_grant"}, bus.OUT_GRANT_ID, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[12];
        int   n;
        int   s;
        tbl = '{
            '{4'b1111, 8'h10, 0}, '{4'b1111, 8'h10, 1},
            '{4'b1111, 8'h10, 2}, '{4'b1111, 8'h10, 3},
            '{4'b1111, 8'h10, 0}, '{4'b0110, 8'h20, 1},
            '{4'b0100, 8'h30, 2}, '{4'b0110, 8'h40, 1},
            '{4'b1001, 8'h50, 3}, '{4'b1001, 8'h60, 0},
            '{4'b0001, 8'h70, 0}, '{4'b1010, 8'h80, 1}
        };
        bus.IN_REQ_VALID = '0;
        bus.IN_REQ_DATA  = '0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // single request from requester 0
        drive(4'b0001, 8'h01);
        expect_grant(0, 8'h01, 1'b0);
        wait_acc(n);
        check("accept_latency", n, 1);
        bus.IN_REQ_VALID = '0;
        check("busy_in_frame", bus.OUT_BUSY, 1);
        tick();
        check("launch_fell", bus.OUT_TX_LAUNCH, 0);
        check("accept_one_cycle", bus.OUT_REQ_ACCEPT, 0);
        wait_fin(n);
        check("busy_gap0", bus.OUT_BUSY, 1);
        tick();
        check("busy_gap1", bus.OUT_BUSY, 1);
        tick();
        check("busy_after_gap", bus.OUT_BUSY, 0);

        // contention and fairness table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].mask, tbl[i].d);
            expect_grant(tbl[i].exp_id, tbl[i].d, 1'b0);
            wait_acc(n);
            if (i == 0) chk_gap = 1'b1;
            if (i == 4) chk_gap = 1'b0;
        end
        bus.IN_REQ_VALID = '0;
        wait_fin(n);
        repeat (4) tick();

        // timeout with a dead UART, then the next request is served
        do_reset();
        m_mode = 1;
        drive(4'b0100, 8'hA0);
        expect_grant(2, 8'hA0, 1'b1);
        wait_acc(n);
        bus.IN_REQ_VALID = 4'b0001;
        expect_grant(0, 8'hA0, 1'b0);
        wait_fin(n);
        check("timeout_latency", n, TMO);
        m_mode = 0;
        wait_acc(n);
        bus.IN_REQ_VALID = '0;
        wait_fin(n);
        repeat (4) tick();

        // DONE on the exact timeout cycle
        m_mode = 2;
        drive(4'b1000, 8'hC0);
        expect_grant(3, 8'hC0, 1'b0);
        wait_acc(n);
        bus.IN_REQ_VALID = '0;
        wait_fin(n);
        check("tie_latency", n, TMO);
        m_mode = 0;
        repeat (4) tick();

        // serve requester 1 so a stale pointer would skip requester 0
        drive(4'b0010, 8'hD0);
        expect_grant(1, 8'hD0, 1'b0);
        wait_acc(n);
        bus.IN_REQ_VALID = '0;
        wait_fin(n);
        repeat (4) tick();

        // reset while waiting for DONE
        drive(4'b0100, 8'hE0);
        expect_grant(2, 8'hE0, 1'b0);
        wait_acc(n);
        bus.IN_REQ_VALID = '0;
        repeat (3) tick();
        check("busy_before_reset", bus.OUT_BUSY, 1);
        s = n_fin;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        q_exp.delete();
        q_done.delete();
        drive(4'b1111, 8'hF0);
        tick();
        tick();
        expect_grant(0, 8'hF0, 1'b0);
        rst_n = 1'b1;
        wait_acc(n);
        check("no_pulse_after_reset", n_fin, s);
        bus.IN_REQ_VALID = '0;
        wait_fin(n);
        repeat (4) tick();
        check("queue_drained", q_exp.size() + q_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
